// File: rtl/vga_timing_generator.sv
// 640x480@60 VGA raster timing: pixel counters plus sync/active/frame decodes.
// Optional define VGA_TIMING_FRAME_COUNTER_EN adds a 16-bit frameCount output.
module vga_timing_generator #(
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33
) (
    input  logic        clk25,
    input  logic        reset,
    output logic        screenEnd,
    output logic        active,
    output logic        hSync,
    output logic        vSync,
    output logic [9:0]  x,
    output logic [8:0]  y
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    ,
    output logic [15:0] frameCount
`endif
);

    localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(WIDTH);
    localparam logic [9:0] V_VIS  = 10'(HEIGHT);
    localparam logic [9:0] HS_BEG = 10'(WIDTH + H_FRONT);
    localparam logic [9:0] HS_END = 10'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(HEIGHT + V_FRONT);
    localparam logic [9:0] VS_END = 10'(HEIGHT + V_FRONT + V_SYNC);

    logic [9:0] h_count;
    logic [9:0] v_count;
    logic       frame_tick;

    // Raster counters: pixel counter wraps each line, line counter each frame.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            if (v_count == V_LAST) begin
                v_count <= '0;
            end else begin
                v_count <= v_count + 10'd1;
            end
        end else begin
            h_count <= h_count + 10'd1;
        end
    end

    // Output decode; reset gates everything to the idle levels immediately.
    always_comb begin
        screenEnd  = 1'b0;
        active     = 1'b0;
        hSync      = 1'b1;
        vSync      = 1'b1;
        x          = h_count;
        y          = v_count[8:0];
        frame_tick = (h_count == 10'd0) && (v_count == V_VIS);
        if (!reset) begin
            screenEnd = frame_tick;
            active    = (h_count < H_VIS) && (v_count < V_VIS);
            hSync     = !((h_count >= HS_BEG) && (h_count < HS_END));
            vSync     = !((v_count >= VS_BEG) && (v_count < VS_END));
        end
    end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
    // Frame counter bumps on the edge where the end-of-frame strobe is high.
    always_ff @(posedge clk25 or posedge reset) begin
        if (reset) begin
            frameCount <= '0;
        end else if (frame_tick) begin
            frameCount <= frameCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: full-size instance for line timing and a tall/narrow
// instance (V_TOTAL > 512) for frame timing, y truncation and frame strobes.
module tb_vga_timing_generator;

    logic clk25 = 1'b0;
    logic reset = 1'b1;

    always #5 clk25 = ~clk25;

    typedef struct packed {
        logic        se;
        logic        act;
        logic        hs;
        logic        vs;
        logic [9:0]  x;
        logic [8:0]  y;
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        logic [15:0] fc;
`endif
    } obs_t;

    logic se0, act0, hs0, vs0, se1, act1, hs1, vs1;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    obs_t obs0, obs1;

`ifdef VGA_TIMING_FRAME_COUNTER_EN
    logic [15:0] fc0, fc1;
    assign obs0 = {se0, act0, hs0, vs0, x0, y0, fc0};
    assign obs1 = {se1, act1, hs1, vs1, x1, y1, fc1};
`else
    assign obs0 = {se0, act0, hs0, vs0, x0, y0};
    assign obs1 = {se1, act1, hs1, vs1, x1, y1};
`endif

    vga_timing_generator dut0 (
        .clk25     (clk25),
        .reset     (reset),
        .screenEnd (se0),
        .active    (act0),
        .hSync     (hs0),
        .vSync     (vs0),
        .x         (x0),
        .y         (y0)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        ,
        .frameCount(fc0)
`endif
    );

    vga_timing_generator #(
        .WIDTH(8), .HEIGHT(500),
        .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_FRONT(10), .V_SYNC(2), .V_BACK(8)
    ) dut1 (
        .clk25     (clk25),
        .reset     (reset),
        .screenEnd (se1),
        .active    (act1),
        .hSync     (hs1),
        .vSync     (vs1),
        .x         (x1),
        .y         (y1)
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        ,
        .frameCount(fc1)
`endif
    );

    int checks = 0;
    int passes = 0;
    int t = 0;
    int exp_pulses = 0;
    int got_pulses = 0;
    obs_t q0[$];
    obs_t q1[$];

    // Reference: position is cycles-since-release modulo line/frame length.
    function automatic obs_t model(bit r, int tt, int W, int H, int HF,
                                   int HS, int HB, int VF, int VS, int VB);
        obs_t o;
        int ht, vt, ft, h, v, t0;
        ht = W + HF + HS + HB;
        vt = H + VF + VS + VB;
        ft = ht * vt;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (r) return o;
        h = tt % ht;
        v = (tt / ht) % vt;
        o.act = (h < W) && (v < H);
        o.hs = !(h >= W + HF && h < W + HF + HS);
        o.vs = !(v >= H + VF && v < H + VF + VS);
        o.se = (h == 0) && (v == H);
        o.x = 10'(h);
        o.y = 9'(v % 512);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
        t0 = H * ht;
        o.fc = (tt > t0) ? 16'(((tt - t0 - 1) / ft + 1) % 65536) : 16'd0;
`else
        t0 = 0;
`endif
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s @%0t got se=%b act=%b hs=%b vs=%b x=%0d y=%0d (%h) want se=%b act=%b hs=%b vs=%b x=%0d y=%0d (%h)",
                     name, $time, got.se, got.act, got.hs, got.vs, got.x, got.y, got,
                     exp.se, exp.act, exp.hs, exp.vs, exp.x, exp.y, exp);
        end
    endtask

    task automatic cyc(input bit r);
        obs_t e1;
        reset = r;
        if (r) t = 0;
        q0.push_back(model(r, t, 640, 480, 16, 96, 48, 10, 2, 33));
        e1 = model(r, t, 8, 500, 2, 2, 2, 10, 2, 8);
        if (e1.se) exp_pulses++;
        q1.push_back(e1);
        @(posedge clk25);
        if (!r) t++;
        #2;
    endtask

    // Monitor: DUT outputs are valid every cycle; compare mid-cycle.
    always @(negedge clk25) begin
        obs_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0", obs0, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1", obs1, e);
            if (obs1.se) got_pulses++;
        end
    end

    initial begin
        int n;
        int m;
        @(posedge clk25);
        #2;
        repeat (5) cyc(1'b1);
        repeat (21860) cyc(1'b0);
        for (int k = 0; k < 3; k++) begin
            n = $urandom_range(3000, 300);
            m = $urandom_range(4, 1);
            repeat (n) cyc(1'b0);
            repeat (m) cyc(1'b1);
        end
        repeat (900) cyc(1'b0);
        @(negedge clk25);
        #1;
        checks++;
        if (q0.size() == 0 && q1.size() == 0) passes++;
        else $display("FAIL drain got q0=%0d q1=%0d want 0 0", q0.size(), q1.size());
        checks++;
        if (got_pulses == exp_pulses && exp_pulses >= 3) passes++;
        else $display("FAIL pulses got %0d want %0d", got_pulses, exp_pulses);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
